// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator:
// FSM state encoding, default pattern and gap counter width.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  localparam int                         DEFAULT_PAT_LEN = 5;
  localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 5'b11011;
  localparam int                         GAP_W           = 8;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/data bundle between a stimulus master and the serial pattern
// generator: start/abort request side plus the serial stream and status.
interface seq_pattern_gen_if #(
  parameter int CNT_W = 8
);

  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_cnt, abort,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, repeat_cnt, abort,
    output out, out_valid, busy, done
  );

endinterface

// File: rtl/seq_gen_down_cnt.sv
// Loadable down counter with a zero flag; load wins over decrement and the
// caller only decrements a non-zero count, so the value never wraps.
module seq_gen_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern transmitter: sends PATTERN MSB first, N times, with GAP
// idle cycles between repeats. Define SEQ_GEN_OVERLAP_EN to skip the leading
// OVL_LEN bits of every repeat after the first when GAP is 0.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
  parameter int                 GAP     = 0,
  parameter int                 CNT_W   = 8,
  parameter int                 OVL_LEN = 2
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);

  localparam int                 IDX_W     = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0]   FIRST_IDX = IDX_W'(PAT_LEN - 1);
`ifdef SEQ_GEN_OVERLAP_EN
  localparam logic [IDX_W-1:0]   RPT_IDX   = IDX_W'(PAT_LEN - 1 - OVL_LEN);
`else
  localparam logic [IDX_W-1:0]   RPT_IDX   = FIRST_IDX;
`endif

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_chk_len
    $error("seq_pattern_gen: PAT_LEN must be in 2..16");
  end
  if (OVL_LEN < 0 || OVL_LEN >= PAT_LEN) begin : g_chk_ovl
    $error("seq_pattern_gen: OVL_LEN must be in 0..PAT_LEN-1");
  end
  if (GAP < 0 || GAP > 255) begin : g_chk_gap
    $error("seq_pattern_gen: GAP must be in 0..255");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   rep_left;
  logic               rep_zero, rep_load, rep_dec;
  logic [GAP_W-1:0]   gap_cnt;
  logic               gap_zero, gap_load, gap_dec;
  logic               out_q, out_valid_q, busy_q, done_q;

  seq_gen_down_cnt #(.W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rep_load),
    .dec      (rep_dec & ~rep_zero),
    .load_val (bus.repeat_cnt),
    .count    (rep_left),
    .zero     (rep_zero)
  );

  seq_gen_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .dec      (gap_dec & ~gap_zero),
    .load_val (GAP_W'(GAP)),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  // The GAP parameter hides the imported GAP state literal, so the state is
  // always referenced with its package scope.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    rep_load  = 1'b0;
    rep_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.repeat_cnt != '0) begin
            state_d   = SEND;
            bit_idx_d = FIRST_IDX;
            rep_load  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end else if (rep_left == CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          rep_dec = 1'b1;
          if (GAP > 0) begin
            state_d  = seq_gen_pkg::GAP;
            gap_load = 1'b1;
          end else begin
            bit_idx_d = RPT_IDX;
          end
        end
      end
      seq_gen_pkg::GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          gap_dec = 1'b1;
          if (gap_cnt == GAP_W'(1)) begin
            state_d   = SEND;
            bit_idx_d = FIRST_IDX;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      out_q       <= (state_d == SEND) && PATTERN[bit_idx_d];
      out_valid_q <= (state_d == SEND);
      busy_q      <= (state_d == SEND) || (state_d == seq_gen_pkg::GAP);
      done_q      <= (state_d == DONE);
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench: two generators (GAP=0 and GAP=2) share one random
// stimulus and are compared every cycle against a queue-based stream model.
module tb_seq_pattern_gen;

  localparam int         PLEN = 5;
  localparam logic [4:0] PAT  = 5'b11011;
  localparam int         OVL  = 2;

  typedef struct packed {
    logic o;
    logic v;
    logic b;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] repeat_cnt = 8'd0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  exp_t cur    [2];
  exp_t stream [2][64];
  int   rd     [2];
  int   wr     [2];

  logic [31:0] cap_o [2];
  logic [31:0] cap_v [2];
  logic [31:0] cap_b [2];
  logic [31:0] cap_d [2];

  seq_pattern_gen_if #(.CNT_W(8)) if0 ();
  seq_pattern_gen_if #(.CNT_W(8)) if1 ();

  assign if0.start      = start;
  assign if0.repeat_cnt = repeat_cnt;
  assign if0.abort      = abort;
  assign if1.start      = start;
  assign if1.repeat_cnt = repeat_cnt;
  assign if1.abort      = abort;

  seq_pattern_gen #(.GAP(0), .CNT_W(8), .OVL_LEN(OVL)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  seq_pattern_gen #(.GAP(2), .CNT_W(8), .OVL_LEN(OVL)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic [3:0] obs(input int k);
    if (k == 0) return {if0.out, if0.out_valid, if0.busy, if0.done};
    return {if1.out, if1.out_valid, if1.busy, if1.done};
  endfunction

  function automatic bit idle(input int k);
    return !cur[k].b && !cur[k].d && (rd[k] >= wr[k]);
  endfunction

  task automatic push(input int k, input exp_t e);
    stream[k][wr[k]] = e;
    wr[k]++;
  endtask

  // Expected per-cycle outputs of a whole transfer, starting one cycle after start.
  task automatic build(input int k, input int n);
    exp_t e;
    rd[k] = 0;
    wr[k] = 0;
    for (int r = 0; r < n; r++) begin
      int first;
      first = PLEN - 1;
`ifdef SEQ_GEN_OVERLAP_EN
      if (r > 0 && gap_of(k) == 0) first = PLEN - 1 - OVL;
`endif
      for (int i = first; i >= 0; i--) begin
        e = '{o: PAT[i], v: 1'b1, b: 1'b1, d: 1'b0};
        push(k, e);
      end
      if (r < n - 1) begin
        for (int g = 0; g < gap_of(k); g++) begin
          e = '{o: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0};
          push(k, e);
        end
      end
    end
    e = '{o: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1};
    push(k, e);
  endtask

  // Reference model: advances on every rising edge from the sampled inputs.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rd[k] = 0; wr[k] = 0; cur[k] = '0;
      end else if (cur[k].b && abort) begin
        rd[k] = 0; wr[k] = 0; cur[k] = '0;
      end else if (rd[k] < wr[k]) begin
        cur[k] = stream[k][rd[k]];
        rd[k]++;
      end else if (cur[k].d) begin
        cur[k] = '0;
      end else if (start) begin
        build(k, int'(repeat_cnt));
        cur[k] = stream[k][0];
        rd[k]  = 1;
      end else begin
        cur[k] = '0;
      end
    end
    cyc++;
    armed = 1'b1;
  end

  // Every-cycle comparison on the falling edge.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int k = 0; k < 2; k++)
        check($sformatf("dut%0d_cyc%0d {out,valid,busy,done}", k, cyc), 32'(obs(k)), 32'(cur[k]));
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(idle(0) && idle(1)) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait: model still busy after %0d cycles", guard);
    end
  endtask

  // Directed transfer: start at a falling edge, then capture len cycles.
  task automatic run_dir(input int test, input int rc, input int len);
    for (int k = 0; k < 2; k++) begin
      cap_o[k] = '0; cap_v[k] = '0; cap_b[k] = '0; cap_d[k] = '0;
    end
    wait_idle();
    start      = 1'b1;
    repeat_cnt = 8'(rc);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic [3:0] s;
        s = obs(k);
        cap_o[k] = {cap_o[k][30:0], s[3]};
        cap_v[k] = {cap_v[k][30:0], s[2]};
        cap_b[k] = {cap_b[k][30:0], s[1]};
        cap_d[k] = {cap_d[k][30:0], s[0]};
      end
      if (c == 1) start = 1'b0;
      case (test)
        1: begin
          if (c == 3) begin start = 1'b1; repeat_cnt = 8'd1; end
          if (c == 4) start = 1'b0;
        end
        4: begin
          if (c == 2) abort = 1'b1;
          if (c == 3) abort = 1'b0;
        end
        5: begin
          if (c == 3) rst = 1'b1;
          if (c == 4) rst = 1'b0;
          if (c == 5) begin start = 1'b1; repeat_cnt = 8'd1; end
          if (c == 6) start = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset dut0", 32'(obs(0)), 32'd0);
    check("reset dut1", 32'(obs(1)), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pattern, with a second start in cycle 3 that must be ignored.
    run_dir(1, 1, 7);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("A dut%0d out", k),   cap_o[k], 32'b1101100);
      check($sformatf("A dut%0d valid", k), cap_v[k], 32'b1111100);
      check($sformatf("A dut%0d busy", k),  cap_b[k], 32'b1111100);
      check($sformatf("A dut%0d done", k),  cap_d[k], 32'b0000010);
    end

    // Three repeats: back-to-back (or overlapped) on dut0, 2-cycle gaps on dut1.
    run_dir(2, 3, 20);
`ifdef SEQ_GEN_OVERLAP_EN
    check("B dut0 out",   cap_o[0], 32'b11011011011000000000);
    check("B dut0 valid", cap_v[0], 32'b11111111111000000000);
    check("B dut0 done",  cap_d[0], 32'b00000000000100000000);
`else
    check("B dut0 out",   cap_o[0], 32'b11011110111101100000);
    check("B dut0 valid", cap_v[0], 32'b11111111111111100000);
    check("B dut0 done",  cap_d[0], 32'b00000000000000010000);
`endif
    check("B dut1 out",   cap_o[1], 32'b11011001101100110110);
    check("B dut1 valid", cap_v[1], 32'b11111001111100111110);
    check("B dut1 busy",  cap_b[1], 32'b11111111111111111110);
    check("B dut1 done",  cap_d[1], 32'b00000000000000000001);

    // Zero repeats: immediate done, never busy.
    run_dir(3, 0, 3);
    check("C dut0 done",  cap_d[0], 32'b100);
    check("C dut0 busy",  cap_b[0], 32'b000);
    check("C dut0 valid", cap_v[0], 32'b000);

    // Abort during cycle 2 of a two-repeat transfer.
    run_dir(4, 2, 10);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("D dut%0d valid", k), cap_v[k], 32'b1100000000);
      check($sformatf("D dut%0d busy", k),  cap_b[k], 32'b1100000000);
      check($sformatf("D dut%0d done", k),  cap_d[k], 32'b0000000000);
    end

    // Reset during cycle 3, then a clean restart.
    run_dir(5, 1, 11);
    check("E dut0 out",   cap_o[0], 32'b11000110110);
    check("E dut0 valid", cap_v[0], 32'b11100111110);
    check("E dut0 busy",  cap_b[0], 32'b11100111110);
    check("E dut0 done",  cap_d[0], 32'b00000000001);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      repeat_cnt = 8'($urandom_range(0, 4));
      abort      = ($urandom_range(0, 29) == 0) && !start;
      rst        = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
